// File: rtl/riscv_pkg.sv
// Opcode constants and fetch state encoding shared by fetch, imem and decoder.
package riscv_pkg;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_RUN      = 3'd2,
    ST_MEM_HOLD = 3'd3,
    ST_HALT     = 3'd4
  } fetch_state_t;

  // Loads and stores both stall the sequencer for the memory wait.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch <-> instruction memory / decoder bundle.
interface fetch_pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic [WIDTH-1:0] imm_b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] offset;
  logic             halted;
  logic             fault;
  logic [WIDTH-1:0] retired;

  modport master (
    output opcode, branch_taken, imm_b,
    input  pc, offset, halted, fault, retired
  );

  modport slave (
    input  opcode, branch_taken, imm_b,
    output pc, offset, halted, fault, retired
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter sequencer: sequential advance, branch redirect with refill,
// load/store hold and halt on NO-OP or end of program.
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       NUM_INST = 18,
  parameter int unsigned       FILL     = 2,
  parameter int unsigned       MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_unit_if.slave   bus
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned FCW = (FILL < 2) ? 2 : $clog2(FILL + 1);
  localparam int unsigned WCW = (MEM_WAIT < 2) ? 2 : $clog2(MEM_WAIT + 1);
  localparam logic [W1-1:0] LAST_PC = W1'(RESET_PC) + W1'(4 * (NUM_INST - 1));

  fetch_state_t     state, state_n;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] offset_q, offset_n;
  logic [WIDTH-1:0] retired_q, retired_n;
  logic             halted_q, halted_n;
  logic             fault_q, fault_n;
  logic [FCW-1:0]   fill_cnt, fill_n;
  logic [WCW-1:0]   wait_cnt, wait_n;

  logic [W1-1:0]    seq_pc_w;
  logic             seq_oob;
  logic [WIDTH-1:0] target;
  logic             tgt_bad;

  // Next-PC candidates; range checks done one bit wider to catch wrap.
  assign seq_pc_w = {1'b0, pc_q} + W1'(4);
  assign seq_oob  = seq_pc_w > LAST_PC;
  assign target   = pc_q + bus.imm_b;
  assign tgt_bad  = (target[1:0] != 2'b00) || (target < RESET_PC) ||
                    ({1'b0, target} > LAST_PC);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_q      <= RESET_PC;
      offset_q  <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      fill_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      pc_q      <= pc_n;
      offset_q  <= offset_n;
      retired_q <= retired_n;
      halted_q  <= halted_n;
      fault_q   <= fault_n;
      fill_cnt  <= fill_n;
      wait_cnt  <= wait_n;
    end
  end

  // Next-state and next-output decision.
  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    offset_n  = '0;
    retired_n = retired_q;
    halted_n  = halted_q;
    fault_n   = fault_q;
    fill_n    = fill_cnt;
    wait_n    = wait_cnt;
    case (state)
      ST_IDLE: begin
        state_n = ST_FILL;
        fill_n  = FCW'(FILL);
      end
      ST_FILL: begin
        if (fill_cnt <= FCW'(1)) begin
          fill_n  = '0;
          state_n = ST_RUN;
        end else begin
          fill_n = fill_cnt - FCW'(1);
        end
      end
      ST_RUN: begin
        if (bus.opcode == OP_NOP) begin
          state_n  = ST_HALT;
          halted_n = 1'b1;
        end else if ((bus.opcode == OP_BRANCH) && bus.branch_taken) begin
          if (tgt_bad) begin
            state_n  = ST_HALT;
            halted_n = 1'b1;
            fault_n  = 1'b1;
          end else begin
            pc_n      = target;
            offset_n  = bus.imm_b;
            retired_n = retired_q + WIDTH'(1);
            fill_n    = FCW'(FILL);
            state_n   = ST_FILL;
          end
        end else if (is_mem_op(bus.opcode)) begin
          retired_n = retired_q + WIDTH'(1);
          wait_n    = WCW'(MEM_WAIT);
          state_n   = ST_MEM_HOLD;
        end else begin
          retired_n = retired_q + WIDTH'(1);
          if (seq_oob) begin
            state_n  = ST_HALT;
            halted_n = 1'b1;
          end else begin
            pc_n    = seq_pc_w[WIDTH-1:0];
            fill_n  = FCW'(FILL);
            state_n = ST_FILL;
          end
        end
      end
      ST_MEM_HOLD: begin
        if (wait_cnt <= WCW'(1)) begin
          wait_n = '0;
          if (seq_oob) begin
            state_n  = ST_HALT;
            halted_n = 1'b1;
          end else begin
            pc_n    = seq_pc_w[WIDTH-1:0];
            fill_n  = FCW'(FILL);
            state_n = ST_FILL;
          end
        end else begin
          wait_n = wait_cnt - WCW'(1);
        end
      end
      ST_HALT: begin
        offset_n = offset_q;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.offset  = offset_q;
  assign bus.retired = retired_q;
  assign bus.halted  = halted_q;
  assign bus.fault   = fault_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter sequencer sitting directly upstream of the instruction memory: generates the `pc` and `offset` the memory indexes with, and consumes the decoded `opcode` it returns. Handles sequential advance, taken-branch redirect with pipeline refill, load/store hold cycles, and halting at end of program (NO-OP or out-of-range PC). Single-issue, in-order, one instruction retired per advance.

## Interface
- `WIDTH`, 32, PC/data width
- `RESET_PC`, 0, PC value after reset; word-aligned
- `NUM_INST`, 18, program length in words; valid PCs are `RESET_PC` to `RESET_PC+4*(NUM_INST-1)`
- `FILL`, 2, cycles from a PC change until the matching `opcode` is valid (memory latency)
- `MEM_WAIT`, 1, extra hold cycles for load/store; at least 1

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  decoded opcode of the instruction at the current `pc`
- `branch_taken`  in  1  compare result for the current branch; sampled only when `opcode`==BRANCH
- `imm_b`  in  WIDTH  sign-extended B-type displacement, bytes
- `pc`  out  WIDTH  current program counter
- `offset`  out  WIDTH  displacement applied on the last redirect; 0 otherwise
- `halted`  out  1  sticky end-of-execution flag
- `fault`  out  1  sticky; set on a misaligned or out-of-range branch target
- `retired`  out  WIDTH  count of instructions accepted

## Operation
- States: IDLE, FILL, RUN, MEM_HOLD, HALT.
- Reset: state IDLE, `pc`=RESET_PC, `offset`=0, `halted`=0, `fault`=0, `retired`=0, fill counter=0, wait counter=0.
- IDLE → FILL after one cycle, with fill counter loaded to FILL.
- FILL: `opcode` ignored; counter decrements each cycle; at 0 → RUN. `pc` held.
- RUN, per-cycle decision on `opcode`, in priority order:
  - 7'b0000000 (NO-OP) → HALT; `pc` held; not retired.
  - BRANCH (7'b1100011) with `branch_taken`=1: target=`pc`+`imm_b`, modulo 2^WIDTH. If target[1:0]≠0 or target is outside the valid range → HALT with `fault`=1. Otherwise `pc`←target, `offset`←`imm_b`, retired+1, → FILL (refill).
  - LOAD (7'b0000011) or STORE (7'b0100011): retired+1, wait counter←MEM_WAIT, → MEM_HOLD; `pc` held.
  - Any other opcode, including an untaken branch: if `pc`+4 is beyond the valid range → HALT (no fault, retired+1); else `pc`←`pc`+4, retired+1, → FILL.
- MEM_HOLD: wait counter decrements; at 0, apply the sequential-advance rule above (including the end-of-range check) and → FILL.
- `offset` returns to 0 on any cycle that is not a redirect.
- HALT: every output frozen; `halted`=1. Only `rst` exits.
- `retired` wraps modulo 2^WIDTH; no saturation.
- `rst` in any state, including mid-FILL or mid-MEM_HOLD, restores the reset values on the next edge; no partial retirement.

## Timing
- All outputs are registered. `pc` changes only on the edge that leaves RUN or MEM_HOLD.
- Sequential instruction: 1 RUN cycle + FILL cycles = FILL+1 cycles per instruction (3 at defaults).
- Load/store: 1 + MEM_WAIT + FILL cycles.
- Taken branch: `pc` and `offset` update on the same edge; `offset` is non-zero for exactly one cycle.
- First RUN cycle after reset: edge 1+FILL (edge 3 at defaults).
- `halted` and `fault` assert on the edge that enters HALT.

## Structure
- Shared package `riscv_pkg`: opcode constants OP_NOP, OP_BRANCH, OP_LOAD, OP_STORE, OP_OP, OP_IMM, and the state enum `fetch_state_t`. The instruction memory and the control decoder reuse them.
- Single module. The fill and wait counters are inline, 2–3 bits each, sized with $clog2. No sub-module.

## Test plan
- Reset, then opcode stream ADDI,ADD,NO-OP → `pc` 0→4→8, advancing every 3 cycles; `halted`=1 with `pc`=8 and `retired`=2.
- Taken BEQ at `pc`=12 with `imm_b`=8 → `pc`=20, `offset`=8 for one cycle then 0; the next 2 cycles of `opcode` are ignored even if 0.
- Taken branch with `imm_b`=6 → HALT, `fault`=1, `pc` unchanged; branch with `imm_b`=-16 at `pc`=8 → `fault`=1.
- LW at `pc`=16 with MEM_WAIT=1 → `pc` holds for 2 cycles, then goes to 20; `retired` increments once.
- Sequential run to `pc`=68 with NUM_INST=18, non-NO-OP opcode → HALT, `fault`=0, `pc`=68.
- Assert `rst` mid-MEM_HOLD → next cycle `pc`=0, `retired`=0, `halted`=0, state IDLE.
